// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) arithmetic primitives.
package gf_pkg;

  localparam int GF_WIDTH_DEFAULT = 8;

  typedef logic [GF_WIDTH_DEFAULT-1:0] gf_elem_t;

  // Field addition is carry-free: each bit is added modulo 2.
  function automatic gf_elem_t gf_add(input gf_elem_t a, input gf_elem_t b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/gf_pipe_stage.sv
// Optional pipeline stage for a data word plus its strobe.
// EN=1 gives a free-running register with synchronous active-low clear; EN=0 gives plain wires.
module gf_pipe_stage #(
  parameter int W  = 8,
  parameter bit EN = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_strb,
  output logic [W-1:0] o_data,
  output logic         o_strb
);

  generate
    if (EN) begin : g_reg
      logic [W-1:0] r_data;
      logic         r_strb;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_data <= '0;
          r_strb <= 1'b0;
        end else begin
          r_data <= i_data;
          r_strb <= i_strb;
        end
      end

      assign o_data = r_data;
      assign o_strb = r_strb;
    end else begin : g_bypass
      // Clock and reset have no load in the bypass form.
      logic w_unused_ctrl;
      assign w_unused_ctrl = i_clk ^ i_rst_n;

      assign o_data = i_data;
      assign o_strb = i_strb;
    end
  endgenerate

endmodule

// File: rtl/gf_adder.sv
// GF(2^WIDTH) adder (bitwise XOR) with optional input/output register stages and a done strobe.
// Define GF_ADDER_ZERO_FLAG_EN to add the o_zero output (high when the sum is zero).
module gf_adder
  import gf_pkg::*;
#(
  parameter int WIDTH   = GF_WIDTH_DEFAULT,
  parameter int REG_IN  = 0,
  parameter int REG_OUT = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             i_start,
  output logic [WIDTH-1:0] out,
`ifdef GF_ADDER_ZERO_FLAG_EN
  output logic             o_zero,
`endif
  output logic             o_done
);

`ifdef GF_ADDER_ZERO_FLAG_EN
  localparam int OUT_W = WIDTH + 1;
`else
  localparam int OUT_W = WIDTH;
`endif

  logic [2*WIDTH-1:0] w_ops;
  logic               w_start;
  logic [WIDTH-1:0]   w_sum;
  logic [OUT_W-1:0]   w_out_d;
  logic [OUT_W-1:0]   w_out_q;

  gf_pipe_stage #(
    .W  (2*WIDTH),
    .EN (REG_IN != 0)
  ) u_in_stage (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  ({in_1, in_2}),
    .i_strb  (i_start),
    .o_data  (w_ops),
    .o_strb  (w_start)
  );

  assign w_sum = w_ops[2*WIDTH-1:WIDTH] ^ w_ops[WIDTH-1:0];

  // The zero flag rides in the output stage with the sum so both share latency and clear value.
`ifdef GF_ADDER_ZERO_FLAG_EN
  assign w_out_d = {(w_sum == '0), w_sum};
`else
  assign w_out_d = w_sum;
`endif

  gf_pipe_stage #(
    .W  (OUT_W),
    .EN (REG_OUT != 0)
  ) u_out_stage (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (w_out_d),
    .i_strb  (w_start),
    .o_data  (w_out_q),
    .o_strb  (o_done)
  );

  assign out = w_out_q[WIDTH-1:0];
`ifdef GF_ADDER_ZERO_FLAG_EN
  assign o_zero = w_out_q[WIDTH];
`endif

endmodule

// File: tb/tb_gf_adder.sv
// Self-checking bench for gf_adder across four register configurations.
module tb_gf_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // d00: WIDTH=8, combinational
  logic [7:0]  a00, b00, o00;
  logic        s00, d00;
  // d11: WIDTH=8, REG_IN=1, REG_OUT=1
  logic [7:0]  a11, b11, o11;
  logic        s11, d11;
  // d10: WIDTH=8, REG_IN=1, REG_OUT=0
  logic [7:0]  a10, b10, o10;
  logic        s10, d10;
  // d01: WIDTH=16, REG_OUT=1
  logic [15:0] a01, b01, o01;
  logic        s01, d01;
`ifdef GF_ADDER_ZERO_FLAG_EN
  logic z00, z11, z10, z01;
`endif

  gf_adder #(.WIDTH(8), .REG_IN(0), .REG_OUT(0)) u_d00 (
    .i_clk(clk), .i_rst_n(rst_n), .in_1(a00), .in_2(b00), .i_start(s00),
    .out(o00),
`ifdef GF_ADDER_ZERO_FLAG_EN
    .o_zero(z00),
`endif
    .o_done(d00));

  gf_adder #(.WIDTH(8), .REG_IN(1), .REG_OUT(1)) u_d11 (
    .i_clk(clk), .i_rst_n(rst_n), .in_1(a11), .in_2(b11), .i_start(s11),
    .out(o11),
`ifdef GF_ADDER_ZERO_FLAG_EN
    .o_zero(z11),
`endif
    .o_done(d11));

  gf_adder #(.WIDTH(8), .REG_IN(1), .REG_OUT(0)) u_d10 (
    .i_clk(clk), .i_rst_n(rst_n), .in_1(a10), .in_2(b10), .i_start(s10),
    .out(o10),
`ifdef GF_ADDER_ZERO_FLAG_EN
    .o_zero(z10),
`endif
    .o_done(d10));

  gf_adder #(.WIDTH(16), .REG_IN(0), .REG_OUT(1)) u_d01 (
    .i_clk(clk), .i_rst_n(rst_n), .in_1(a01), .in_2(b01), .i_start(s01),
    .out(o01),
`ifdef GF_ADDER_ZERO_FLAG_EN
    .o_zero(z01),
`endif
    .o_done(d01));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference history: what each DUT saw at every clock edge.
  logic [15:0] h16 [0:2047];
  logic        hs16[0:2047];
  logic [7:0]  h8  [0:2047];
  logic        hs8 [0:2047];
  logic        hr  [0:2047];
  int          ne = 0;

  always @(posedge clk) begin
    h16[ne]  <= a01 ^ b01;
    hs16[ne] <= s01;
    h8[ne]   <= a11 ^ b11;
    hs8[ne]  <= s11;
    hr[ne]   <= rst_n;
    ne       <= ne + 1;
  end

  // Result visible after edge k for latency L: operands from edge k-L+1,
  // unless any edge in that window saw reset, which leaves everything zero.
  function automatic logic [17:0] model(input int k, input int lat, input bit wide);
    int j0;
    logic [15:0] x;
    logic s;
    j0 = k - lat + 1;
    for (int j = j0; j <= k; j++)
      if (hr[j] == 1'b0) return '0;
    x = wide ? h16[j0] : {8'h00, h8[j0]};
    s = wide ? hs16[j0] : hs8[j0];
    return {(x == 16'h0), s, x};
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] eo;
    logic       ed;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [17:0] m;
    int k;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'hE9, 8'h05, 1'b1, 8'hEC, 1'b1};
    tbl[2] = '{8'hE9, 8'h05, 1'b0, 8'hEC, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1};
    tbl[4] = '{8'h12, 8'h34, 1'b0, 8'h26, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 8'h81, 1'b1};

    rst_n = 1'b0;
    {a00, b00, s00, a11, b11, s11, a10, b10, s10, a01, b01, s01} = '0;
    repeat (3) tick();
    #2;
    chk("rst_d11_out", 32'(o11), 32'h0);
    chk("rst_d11_done", 32'(d11), 32'h0);
    chk("rst_d10_out", 32'(o10), 32'h0);
    chk("rst_d10_done", 32'(d10), 32'h0);
    chk("rst_d01_out", 32'(o01), 32'h0);
    chk("rst_d01_done", 32'(d01), 32'h0);
`ifdef GF_ADDER_ZERO_FLAG_EN
    chk("rst_d11_zero", 32'(z11), 32'h0);
    chk("rst_d01_zero", 32'(z01), 32'h0);
`endif

    // Combinational configuration, exercised while reset is still asserted.
    for (int i = 0; i < 6; i++) begin
      tick();
      a00 = tbl[i].a; b00 = tbl[i].b; s00 = tbl[i].s;
      #2;
      chk($sformatf("tbl%0d_out", i), 32'(o00), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_done", i), 32'(d00), 32'(tbl[i].ed));
`ifdef GF_ADDER_ZERO_FLAG_EN
      chk($sformatf("tbl%0d_zero", i), 32'(z00), 32'(tbl[i].eo == 8'h00));
`endif
    end
    rst_n = 1'b1;

    // Latency 2: single pulse.
    tick();
    a11 = 8'hFF; b11 = 8'h0F; s11 = 1'b1;
    tick();
    a11 = 8'($urandom); b11 = 8'($urandom); s11 = 1'b0;
    #2;
    chk("l2_done_c1", 32'(d11), 32'h0);
    tick();
    #2;
    chk("l2_done_c2", 32'(d11), 32'h1);
    chk("l2_out_c2", 32'(o11), 32'hF0);
    tick();
    #2;
    chk("l2_done_c3", 32'(d11), 32'h0);

    // Latency 1: back-to-back starts.
    tick();
    a10 = 8'hA5; b10 = 8'h5A; s10 = 1'b1;
    tick();
    a10 = 8'h3C; b10 = 8'h3C; s10 = 1'b1;
    #2;
    chk("b2b_done0", 32'(d10), 32'h1);
    chk("b2b_out0", 32'(o10), 32'hFF);
`ifdef GF_ADDER_ZERO_FLAG_EN
    chk("b2b_zero0", 32'(z10), 32'h0);
`endif
    tick();
    a10 = 8'h11; b10 = 8'h22; s10 = 1'b0;
    #2;
    chk("b2b_done1", 32'(d10), 32'h1);
    chk("b2b_out1", 32'(o10), 32'h00);
`ifdef GF_ADDER_ZERO_FLAG_EN
    chk("b2b_zero1", 32'(z10), 32'h1);
`endif
    tick();
    #2;
    chk("b2b_done2", 32'(d10), 32'h0);

    // Reset one cycle after a start discards it; start during reset is ignored.
    tick();
    a11 = 8'h11; b11 = 8'h22; s11 = 1'b1;
    tick();
    s11 = 1'b0; rst_n = 1'b0;
    a10 = 8'h77; b10 = 8'h07; s10 = 1'b1;
    tick();
    rst_n = 1'b1;
    a10 = 8'hF0; b10 = 8'h0F; s10 = 1'b1;
    #2;
    chk("mrst_d11_out", 32'(o11), 32'h0);
    chk("mrst_d11_done", 32'(d11), 32'h0);
    chk("mrst_d10_out", 32'(o10), 32'h0);
    chk("mrst_d10_done", 32'(d10), 32'h0);
    tick();
    s10 = 1'b0;
    #2;
    chk("mrst_d11_done_n1", 32'(d11), 32'h0);
    chk("mrst_d11_out_n1", 32'(o11), 32'h0);
    chk("first_start_done", 32'(d10), 32'h1);
    chk("first_start_out", 32'(o10), 32'hFF);
    tick();
    #2;
    chk("mrst_d11_done_n2", 32'(d11), 32'h0);

    // Random traffic with occasional reset, checked against the history model.
    for (int c = 0; c < 1000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 49) != 0);
      a00 = 8'($urandom);  b00 = 8'($urandom);  s00 = 1'($urandom);
      a11 = 8'($urandom);  b11 = 8'($urandom);  s11 = 1'($urandom);
      a01 = 16'($urandom); b01 = 16'($urandom); s01 = 1'($urandom);
      if (c % 7 == 0) b01 = a01;
      if (c % 9 == 0) b11 = a11;
      #2;
      k = ne - 1;
      chk("rnd_d00_out", 32'(o00), 32'(a00 ^ b00));
      chk("rnd_d00_done", 32'(d00), 32'(s00));
      m = model(k, 1, 1'b1);
      chk("rnd_d01_out", 32'(o01), 32'(m[15:0]));
      chk("rnd_d01_done", 32'(d01), 32'(m[16]));
`ifdef GF_ADDER_ZERO_FLAG_EN
      chk("rnd_d01_zero", 32'(z01), 32'(m[17] && hr[k]));
`endif
      m = model(k, 2, 1'b0);
      chk("rnd_d11_out", 32'(o11), 32'(m[7:0]));
      chk("rnd_d11_done", 32'(d11), 32'(m[16]));
`ifdef GF_ADDER_ZERO_FLAG_EN
      chk("rnd_d11_zero", 32'(z11), 32'(m[17] && hr[k] && hr[k-1]));
`endif
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gf_adder.md
Name: gf_adder

Overview:
- Galois-field GF(2^WIDTH) adder: sum = in_1 XOR in_2, bitwise, with no carries.
- Serves as a leaf arithmetic primitive in the common library, used by GF multiply-accumulate and polynomial datapaths.
- Optional input and output register stages trade latency for timing.
- A start/done strobe travels alongside the data so callers can track when the result is valid.

Parameters:
- WIDTH, 8, field element width in bits; legal range ≥1.
- REG_IN, 0, 1 inserts a register stage on in_1, in_2 and i_start; 0 passes them straight through.
- REG_OUT, 0, 1 inserts a register stage on out and o_done; 0 leaves them combinational.

Ports:
- i_clk  input  1  clock; all registers update on the rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- in_1  input  WIDTH  first field element operand.
- in_2  input  WIDTH  second field element operand.
- i_start  input  1  single-cycle strobe marking valid operands.
- out  output  WIDTH  sum in_1 XOR in_2.
- o_done  output  1  strobe marking valid out.

Behaviour:
- Arithmetic: out = in_1 ^ in_2, bitwise over WIDTH bits. There is no overflow and no carry. Every operand value is legal.
- Latency L = REG_IN + REG_OUT cycles, from i_start sampled high to o_done high.
  - o_done is exactly i_start delayed by L cycles.
  - out in the o_done cycle equals the XOR of the operands presented with that i_start.
- L = 0: fully combinational.
  - out and o_done follow the inputs in the same cycle.
  - Reset has no effect on this configuration.
- Register stages are free-running with no enable: data registers load every cycle.
  - out therefore tracks the inputs delayed by L whether or not i_start is high.
  - Callers qualify out with o_done.
- Throughput: one operation per cycle. Back-to-back i_start pulses give back-to-back o_done pulses, each with its own result.
- i_start held high for N cycles gives o_done high for N cycles after L.
- No handshake or backpressure. i_start is never ignored.
- Reset, with i_rst_n sampled low at a clock edge:
  - Every implemented register clears to 0, so out=0 and o_done=0 in register configurations.
  - Reset mid-operation discards in-flight operations; no o_done is produced for them.
  - i_start sampled while i_rst_n is low is discarded.
  - The first valid i_start is the one sampled in the cycle after i_rst_n returns high.
- X-free: no internal state beyond the listed pipeline registers.

Optional Feature:
- Macro: GF_ADDER_ZERO_FLAG_EN.
- Defined: adds output o_zero (1 bit), high when out == 0, i.e. in_1 == in_2.
  - o_zero is aligned with out and has the same latency and reset value, which in registered form is 0.
  - When REG_OUT=1, o_zero is registered alongside out.
- Undefined: the o_zero port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package gf_pkg holds:
  - GF_WIDTH_DEFAULT = 8.
  - A gf_elem_t typedef of logic [GF_WIDTH_DEFAULT-1:0].
- One natural sub-module, gf_pipe_stage: a parameterised register or bypass of width W+1 (data plus strobe), with the synchronous active-low clear.
  - It is instantiated once for the input stage (REG_IN) and once for the output stage (REG_OUT).
  - Each instance becomes wires when its parameter is 0.

Test Plan:
- REG_IN=0, REG_OUT=0, WIDTH=8:
  - Hold in_1=0x00, in_2=0x00, i_start=0 -> out=0x00, o_done=0.
  - Then in_1=0xE9, in_2=0x05, i_start=1 for one cycle -> out=0xEC, o_done=1 in the same cycle; o_done=0 the next cycle.
- REG_IN=1, REG_OUT=1: i_start pulse with in_1=0xFF, in_2=0x0F -> o_done high exactly 2 cycles later with out=0xF0.
- REG_IN=1, REG_OUT=0: back-to-back starts (0xA5^0x5A) then (0x3C^0x3C) -> o_done high for 2 consecutive cycles with out=0xFF then 0x00.
  - With GF_ADDER_ZERO_FLAG_EN, o_zero=0 then 1.
- REG_IN=1, REG_OUT=1: assert i_rst_n=0 one cycle after i_start -> out=0x00 and o_done=0 after the reset edge; no o_done for the discarded operation.
- WIDTH=16, REG_OUT=1: random operands over 1000 cycles -> out equals the 1-cycle-delayed XOR each cycle; o_done tracks i_start delayed by 1.
